// File: rtl/led_pkg.sv
// Shared mode/direction encodings and PWM width for the LED pattern driver.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_BLINK  = 2'd0,
      MODE_WALK   = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   localparam int PWM_W = 4;

endpackage

// File: rtl/led_pattern_driver_tick_edge_sync.sv
// Synchronises the slow divider toggle into i_CLK and flags its rising edges
// with a one-cycle pulse.
module tick_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_CLK,
   input  logic i_RST,
   input  logic i_TICK,
   output logic o_RISE
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   tick_p_q;

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         sync_q   <= '0;
         tick_p_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], i_TICK};
         tick_p_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign o_RISE = sync_q[SYNC_STAGES-1] & ~tick_p_q;

endmodule

// File: rtl/led_pattern_driver.sv
// Steps one of four LED patterns on each synchronised rising edge of i_TICK.
// Optional PWM dimming via i_DUTY when LED_DIM_EN is defined.
//
//   mode_q       | meaning
//   MODE_BLINK   | all LEDs toggle together each step
//   MODE_WALK    | single lit LED rotates toward MSB, wraps to bit 0
//   MODE_BOUNCE  | single lit LED sweeps up and down, reversing at the ends
//   MODE_COUNT   | LEDs show a binary up-counter
module led_pattern_driver
   import led_pkg::*;
#(
   parameter int N_LEDS      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_CLK,
   input  logic              i_RST,
   input  logic              i_TICK,
   input  logic              i_EN,
   input  logic [1:0]        i_MODE,
`ifdef LED_DIM_EN
   input  logic [PWM_W-1:0]  i_DUTY,
`endif
   output logic [N_LEDS-1:0] o_LED,
   output logic              o_STEP
);

   localparam logic [N_LEDS-1:0] LED_SEED = {{(N_LEDS-1){1'b0}}, 1'b1};

   logic              rise;
   logic              step;
   logic              onehot;
   logic              going_up;
   logic [N_LEDS-1:0] led_q, led_d;
   mode_e             mode_q, mode_d;
   dir_e              dir_q, dir_d;
   logic              step_q;

   tick_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .i_TICK(i_TICK),
      .o_RISE(rise)
   );

   assign step   = rise & i_EN;
   assign onehot = (led_q != '0) && ((led_q & (led_q - LED_SEED)) == '0);

   always_comb begin
      led_d    = led_q;
      mode_d   = mode_q;
      dir_d    = dir_q;
      going_up = 1'b0;
      if (step) begin
         if (mode_q != mode_e'(i_MODE)) begin
            mode_d = mode_e'(i_MODE);
            dir_d  = DIR_UP;
            led_d  = (mode_e'(i_MODE) == MODE_BLINK) ? '1 : LED_SEED;
         end else begin
            case (mode_q)
               MODE_BLINK: led_d = ~led_q;
               MODE_WALK:  led_d = onehot ? {led_q[N_LEDS-2:0], led_q[N_LEDS-1]} : LED_SEED;
               MODE_BOUNCE: begin
                  if (!onehot) begin
                     led_d = LED_SEED;
                     dir_d = DIR_UP;
                  end else begin
                     // Reverse on the step that leaves an end bit, so it is never held twice.
                     going_up = ((dir_q == DIR_UP) && !led_q[N_LEDS-1]) ||
                                ((dir_q == DIR_DOWN) && led_q[0]);
                     if (going_up) begin
                        led_d = led_q << 1;
                        dir_d = led_d[N_LEDS-1] ? DIR_DOWN : DIR_UP;
                     end else begin
                        led_d = led_q >> 1;
                        dir_d = led_d[0] ? DIR_UP : DIR_DOWN;
                     end
                  end
               end
               MODE_COUNT: led_d = led_q + LED_SEED;
               default:    led_d = led_q;
            endcase
         end
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         led_q  <= '0;
         mode_q <= MODE_BLINK;
         dir_q  <= DIR_UP;
         step_q <= 1'b0;
      end else begin
         led_q  <= led_d;
         mode_q <= mode_d;
         dir_q  <= dir_d;
         step_q <= step;
      end
   end

   assign o_STEP = step_q;

`ifdef LED_DIM_EN
   logic [PWM_W-1:0] pwm_cnt_q;

   always_ff @(posedge i_CLK) begin
      if (i_RST) pwm_cnt_q <= '0;
      else       pwm_cnt_q <= pwm_cnt_q + 1'b1;
   end

   assign o_LED = led_q & {N_LEDS{pwm_cnt_q < i_DUTY}};
`else
   assign o_LED = led_q;
`endif

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver (N_LEDS=8, SYNC_STAGES=2).
module tb_led_pattern_driver;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       tick = 1'b0;
   logic       en   = 1'b1;
   logic [1:0] mode = 2'd0;
   logic [7:0] led;
   logic       stp;
   logic [7:0] pat;
`ifdef LED_DIM_EN
   logic [3:0] duty = 4'd15;
`endif

   int total = 0;
   int bad   = 0;
   int step_cnt = 0;

   always #5 clk = ~clk;

   led_pattern_driver #(.N_LEDS(8), .SYNC_STAGES(2)) dut (
      .i_CLK (clk),
      .i_RST (rst),
      .i_TICK(tick),
      .i_EN  (en),
      .i_MODE(mode),
`ifdef LED_DIM_EN
      .i_DUTY(duty),
`endif
      .o_LED (led),
      .o_STEP(stp)
   );

`ifdef LED_DIM_EN
   assign pat = dut.led_q;
`else
   assign pat = led;
`endif

   always @(negedge clk) if (stp === 1'b1) step_cnt++;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      tick = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   // One rising edge of tick with full latency/pulse-width checking.
   task automatic step_chk(input logic [7:0] exp, input string nm);
      tick = 1'b1;
      cyc(1);
      total++;
      if (stp !== 1'b0) begin bad++; $display("FAIL %s early_t0: o_STEP=%b expected 0", nm, stp); end
      cyc(1);
      total++;
      if (stp !== 1'b0) begin bad++; $display("FAIL %s early_t1: o_STEP=%b expected 0", nm, stp); end
      cyc(1);
      total++;
      if (stp !== 1'b1) begin bad++; $display("FAIL %s step: o_STEP=%b expected 1", nm, stp); end
      total++;
      if (pat !== exp) begin bad++; $display("FAIL %s led: o_LED=%h expected %h", nm, pat, exp); end
      cyc(1);
      total++;
      if (stp !== 1'b0 || pat !== exp) begin
         bad++;
         $display("FAIL %s hold: o_STEP=%b o_LED=%h expected 0 %h", nm, stp, pat, exp);
      end
      tick = 1'b0;
      cyc(3);
   endtask

   task automatic tick_only();
      tick = 1'b1;
      cyc(3);
      tick = 1'b0;
      cyc(3);
   endtask

   task automatic test_reset();
      en = 1'b1; mode = 2'd0;
      do_reset();
      total++;
      if (pat !== 8'h00 || stp !== 1'b0) begin
         bad++;
         $display("FAIL reset: o_LED=%h o_STEP=%b expected 00 0", pat, stp);
      end
   endtask

   task automatic test_blink();
      int base;
      base = step_cnt;
      step_chk(8'hFF, "blink1");
      step_chk(8'h00, "blink2");
      step_chk(8'hFF, "blink3");
      total++;
      if (step_cnt - base != 3) begin bad++; $display("FAIL blink_pulses: got %0d expected 3", step_cnt - base); end
   endtask

   task automatic test_walk();
      logic [7:0] exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
      do_reset();
      mode = 2'd1;
      for (int i = 0; i < 10; i++) step_chk(exp[i], $sformatf("walk%0d", i));
   endtask

   task automatic test_bounce();
      logic [7:0] exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      do_reset();
      mode = 2'd2;
      for (int i = 0; i < 16; i++) step_chk(exp[i], $sformatf("bounce%0d", i));
   endtask

   task automatic test_count();
      do_reset();
      mode = 2'd3;
      step_chk(8'h01, "count_seed");
      repeat (254) tick_only();
      total++;
      if (pat !== 8'hFF) begin bad++; $display("FAIL count_preload: o_LED=%h expected ff", pat); end
      step_chk(8'h00, "count_wrap");
   endtask

   task automatic test_enable();
      int base;
      do_reset();
      mode = 2'd1;
      step_chk(8'h01, "en_seed");
      base = step_cnt;
      en = 1'b0;
      tick_only();
      tick_only();
      tick = 1'b1;
      cyc(4);
      en = 1'b1;
      cyc(4);
      total++;
      if (pat !== 8'h01 || step_cnt != base) begin
         bad++;
         $display("FAIL en_lost: o_LED=%h steps=%0d expected 01 0", pat, step_cnt - base);
      end
      tick = 1'b0;
      cyc(3);
      step_chk(8'h02, "en_resume");
      total++;
      if (step_cnt - base != 1) begin bad++; $display("FAIL en_once: steps=%0d expected 1", step_cnt - base); end
   endtask

   task automatic test_mode_glitch();
      mode = 2'd3;
      cyc(2);
      mode = 2'd0;
      cyc(1);
      mode = 2'd1;
      cyc(1);
      step_chk(8'h04, "mode_glitch");
   endtask

   task automatic test_reset_mid_bounce();
      do_reset();
      mode = 2'd2;
      step_chk(8'h01, "mid_b0");
      step_chk(8'h02, "mid_b1");
      step_chk(8'h04, "mid_b2");
      rst = 1'b1;
      cyc(1);
      total++;
      if (pat !== 8'h00 || stp !== 1'b0 || dut.mode_q !== 2'd0) begin
         bad++;
         $display("FAIL mid_reset: o_LED=%h o_STEP=%b mode_q=%0d expected 00 0 0", pat, stp, dut.mode_q);
      end
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic test_reset_release();
      rst  = 1'b1;
      tick = 1'b1;
      mode = 2'd0;
      en   = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      total++;
      if (stp !== 1'b0) begin bad++; $display("FAIL rel_e1: o_STEP=%b expected 0", stp); end
      cyc(1);
      total++;
      if (stp !== 1'b0) begin bad++; $display("FAIL rel_e2: o_STEP=%b expected 0", stp); end
      cyc(1);
      total++;
      if (stp !== 1'b1 || pat !== 8'hFF) begin
         bad++;
         $display("FAIL rel_e3: o_STEP=%b o_LED=%h expected 1 ff", stp, pat);
      end
      tick = 1'b0;
      cyc(3);
   endtask

`ifdef LED_DIM_EN
   task automatic test_dim();
      int on_cnt, other;
      do_reset();
      mode = 2'd0;
      step_chk(8'hFF, "dim_seed");
      duty = 4'd4;
      on_cnt = 0; other = 0;
      for (int i = 0; i < 16; i++) begin
         if (led === 8'hFF) on_cnt++;
         else if (led !== 8'h00) other++;
         cyc(1);
      end
      total++;
      if (on_cnt != 4 || other != 0) begin
         bad++;
         $display("FAIL dim4: on=%0d other=%0d expected 4 0", on_cnt, other);
      end
      duty = 4'd0;
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (led !== 8'h00) on_cnt++;
         cyc(1);
      end
      total++;
      if (on_cnt != 0) begin bad++; $display("FAIL dim0: lit=%0d expected 0", on_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_blink();
      test_walk();
      test_bounce();
      test_count();
      test_enable();
      test_mode_glitch();
      test_reset_mid_bounce();
      test_reset_release();
`ifdef LED_DIM_EN
      test_dim();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_pattern_driver.md
Name: led_pattern_driver

Overview:
- Downstream consumer of the 1 Hz divider's toggle output; turns each rising edge of that slow square wave into one "step" of an LED pattern.
- Synchronises the toggle into its own clock domain, detects rising edges, and advances one of four selectable patterns on the board LEDs.
- Sits between the divider and the top-level LED pins.

Parameters:
- N_LEDS, 8, number of LED outputs; legal range 2..32.
- SYNC_STAGES, 2, flops in the i_TICK synchroniser; legal range 2..4.

Ports:
- i_CLK  input  1  system clock; all logic is on its rising edge.
- i_RST  input  1  synchronous, active-high reset.
- i_TICK  input  1  slow toggle from the divider (1 Hz square wave), asynchronous to i_CLK.
- i_EN  input  1  step enable; low freezes the pattern.
- i_MODE  input  2  pattern select: 0 BLINK, 1 WALK, 2 BOUNCE, 3 COUNT.
- o_LED  output  N_LEDS  LED drive, active-high.
- o_STEP  output  1  one-cycle pulse, high in the cycle o_LED takes a new step value.

Behaviour:
- Reset (i_RST high at a clock edge):
  - clears o_LED, o_STEP, the sync chain, the edge-detect flop, mode_q (to BLINK) and dir (to up);
  - takes effect in that cycle and has priority over everything else.
- Synchroniser:
  - i_TICK passes through SYNC_STAGES flops, giving tick_s; tick_p is tick_s delayed by one cycle.
  - step = tick_s & ~tick_p & i_EN.
- Latency:
  - i_TICK first sampled high at edge t0 gives o_LED update and o_STEP=1 at edge t0+SYNC_STAGES.
  - o_STEP is high for exactly one cycle.
- Falling edges of i_TICK are ignored.
- On step, with mode_q != i_MODE (mode change):
  - mode_q <= i_MODE;
  - o_LED loads the seed of the new mode: BLINK all-ones, WALK 1, BOUNCE 1 with dir=up, COUNT 1.
- On step, with mode_q == i_MODE (advance):
  - BLINK: o_LED <= ~o_LED; alternates all-zero and all-ones, so the first step after reset gives all-ones.
  - WALK: rotate left by one; MSB wraps to bit 0.
    - A non-one-hot value (e.g. 0 after reset) is replaced by the seed 1.
  - BOUNCE: single one moves toward the MSB while dir=up.
    - When it reaches the MSB, dir flips to down; the next step moves it to MSB-1.
    - Symmetric at bit 0.
    - The end bit is never held for two steps.
    - A non-one-hot value is replaced by seed 1 with dir=up.
  - COUNT: o_LED <= o_LED + 1 modulo 2^N_LEDS; all-ones wraps to 0.
- No step: o_LED, mode_q and dir hold; o_STEP=0.
- i_EN low:
  - an edge occurring while disabled is lost, not deferred;
  - raising i_EN while i_TICK is steady high causes no step.
- i_MODE changes are only sampled on a step; glitches between steps have no effect.
- Reset release with i_TICK already high: the sync chain sees a 0->1 edge, so a step fires SYNC_STAGES+1 cycles after release (if i_EN=1). This is required behaviour.

Optional Feature:
- Macro: LED_DIM_EN.
- Defined:
  - adds port i_DUTY (input, 4 bits) and a free-running 4-bit pwm_cnt, reset to 0, incrementing every cycle and wrapping 15->0;
  - o_LED = pattern & {N_LEDS{pwm_cnt < i_DUTY}};
  - i_DUTY=0 keeps the LEDs fully off; i_DUTY=15 gives a 15/16 on-time;
  - o_STEP is unaffected.
- Undefined: no i_DUTY port, no pwm_cnt; o_LED is the pattern register directly.

Decomposition:
- Package led_pkg:
  - mode constants MODE_BLINK=2'd0, MODE_WALK=2'd1, MODE_BOUNCE=2'd2, MODE_COUNT=2'd3;
  - DIR_UP/DIR_DOWN;
  - PWM_W=4.
- Sub-module tick_edge_sync: parameterised SYNC_STAGES synchroniser plus rising-edge detector, outputting a one-cycle pulse.
- Pattern FSM and optional PWM stay in the top module.

Test Plan:
- Reset with i_TICK=0, i_EN=1, i_MODE=0, then three i_TICK rising edges -> o_LED = 8'hFF, 8'h00, 8'hFF, each exactly 2 cycles after the edge; o_STEP pulses 3 times, 1 cycle each.
- i_MODE=1 after reset, 10 steps -> o_LED = 01 (seed), 02, 04, 08, 10, 20, 40, 80, 01, 02.
- i_MODE=2, 16 steps -> 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02 (no repeat at the ends).
- i_MODE=3 from seed 1, preload by 254 steps -> 8'hFF; next step -> 8'h00; o_STEP still pulses.
- i_EN=0 across two i_TICK rising edges, then i_EN=1 with i_TICK high -> o_LED unchanged, no o_STEP; the next real edge advances once. Assert i_RST mid-BOUNCE -> o_LED=0, mode_q=BLINK the next cycle.
- LED_DIM_EN with i_DUTY=4, pattern 8'hFF -> o_LED=8'hFF for 4 of every 16 cycles; i_DUTY=0 -> o_LED always 0.
